// File: rtl/hypot_pkg.sv
// Shared FSM encoding and width helpers for the sequential hypotenuse unit.
// Pure declarations, no logic.
package hypot_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        SQRT,
        DONE
    } state_t;

    function automatic int sum_w(input int w);
        return 2 * w + 1;
    endfunction

    function automatic int root_w(input int w);
        return w + 1;
    endfunction

    function automatic int cnt_w(input int w);
        return $clog2(w + 2);
    endfunction

endpackage

// File: rtl/hypot_seq_isqrt.sv
// Restoring bit-pair integer square root, two radicand bits per cycle, MSB first.
// Latency: ROOT_W cycles after start; root/rem are valid combinationally while done is high.
// No backpressure: a start while active restarts the computation.
module seq_isqrt
    import hypot_pkg::*;
#(
    parameter int ROOT_W = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2*ROOT_W-1:0]   radicand,
    output logic                  done,
    output logic [ROOT_W-1:0]     root,
    output logic [ROOT_W:0]       rem
);

    localparam int RAD_W = 2 * ROOT_W;
    localparam int REM_W = ROOT_W + 1;
    localparam int TRY_W = REM_W + 2;
    localparam int CNT_W = cnt_w(ROOT_W - 1);

    logic [RAD_W-1:0]  rad_q;
    logic [ROOT_W-1:0] root_q;
    logic [REM_W-1:0]  rem_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              active;

    logic [TRY_W-1:0]  cur;
    logic [TRY_W-1:0]  trial;
    logic [REM_W-1:0]  diff;

    // Bring down the next bit pair and try subtracting 4*root+1.
    assign cur   = {rem_q, rad_q[RAD_W-1 -: 2]};
    assign trial = {1'b0, root_q, 2'b01};
    // The true difference always fits the remainder width, so modular low bits suffice.
    assign diff  = cur[REM_W-1:0] - trial[REM_W-1:0];

    always_comb begin
        rem  = cur[REM_W-1:0];
        root = {root_q[ROOT_W-2:0], 1'b0};
        if (cur >= trial) begin
            rem  = diff;
            root = {root_q[ROOT_W-2:0], 1'b1};
        end
    end

    assign done = active && (cnt_q == CNT_W'(ROOT_W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rad_q  <= '0;
            root_q <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            active <= 1'b0;
        end else if (start) begin
            rad_q  <= radicand;
            root_q <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            active <= 1'b1;
        end else if (active) begin
            rad_q  <= rad_q << 2;
            root_q <= root;
            rem_q  <= rem;
            cnt_q  <= done ? '0 : cnt_q + CNT_W'(1);
            active <= !done;
        end
    end

endmodule

// File: rtl/hypot_seq.sv
// y = floor(sqrt(a*a + b*b)), or round-to-nearest when HYPOT_ROUND_EN is defined.
// Latency: start accepted at edge 0, ready pulses in the cycle after edge 2*WIDTH+1.
// No backpressure: start is only sampled in IDLE, never queued; busy flags the unit as occupied.
module hypot_seq
    import hypot_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH:0]   y
);

    localparam int SQ_W   = 2 * WIDTH;
    localparam int SUM_W  = sum_w(WIDTH);
    localparam int ROOT_W = root_w(WIDTH);
    localparam int CNT_W  = cnt_w(WIDTH);
`ifdef HYPOT_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  ra;
    logic [WIDTH-1:0]  rb;
    logic [SQ_W-1:0]   acc_a;
    logic [SQ_W-1:0]   acc_b;
    logic [SQ_W-1:0]   acc_a_nxt;
    logic [SQ_W-1:0]   acc_b_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              mul_last;
    logic              bit_a;
    logic              bit_b;
    logic [SUM_W-1:0]  sum;
    logic              sq_start;
    logic              sq_done;
    logic [ROOT_W-1:0] sq_root;
    logic [ROOT_W:0]   sq_rem;
    logic [ROOT_W-1:0] y_nxt;

    assign mul_last = (cnt == CNT_W'(WIDTH - 1));
    assign bit_a    = |(ra & (WIDTH'(1) << cnt));
    assign bit_b    = |(rb & (WIDTH'(1) << cnt));

    // Both squares accumulate in parallel, one multiplier bit per cycle.
    always_comb begin
        acc_a_nxt = acc_a;
        acc_b_nxt = acc_b;
        if (bit_a) acc_a_nxt = acc_a + (SQ_W'(ra) << cnt);
        if (bit_b) acc_b_nxt = acc_b + (SQ_W'(rb) << cnt);
    end

    // The sum is formed from the final partial products and handed straight to the root stage.
    assign sum      = SUM_W'(acc_a_nxt) + SUM_W'(acc_b_nxt);
    assign sq_start = (state == MUL) && mul_last;

    seq_isqrt #(
        .ROOT_W (ROOT_W)
    ) u_isqrt (
        .clk      (clk),
        .rst      (rst),
        .start    (sq_start),
        .radicand ({1'b0, sum}),
        .done     (sq_done),
        .root     (sq_root),
        .rem      (sq_rem)
    );

    // rem > root means s is closer to (root+1)^2; ties are impossible for integer s.
    assign y_nxt = sq_root + ROOT_W'(ROUND_EN && (sq_rem > {1'b0, sq_root}));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = MUL;
            MUL:     if (mul_last) state_nxt = SQRT;
            SQRT:    if (sq_done) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy  = (state == MUL) || (state == SQRT);
    assign ready = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra    <= '0;
            rb    <= '0;
            acc_a <= '0;
            acc_b <= '0;
            cnt   <= '0;
            y     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ra    <= a;
                        rb    <= b;
                        acc_a <= '0;
                        acc_b <= '0;
                        cnt   <= '0;
                    end
                end
                MUL: begin
                    acc_a <= acc_a_nxt;
                    acc_b <= acc_b_nxt;
                    cnt   <= mul_last ? '0 : cnt + CNT_W'(1);
                end
                SQRT: begin
                    if (sq_done) y <= y_nxt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hypot_seq.sv
// Bench for hypot_seq: instances at WIDTH 4, 8, 12, 16 run in parallel, each checked every
// cycle against an arithmetic model of acceptance timing and the expected result.
module tb_hypot_seq;

`ifdef HYPOT_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    typedef struct {
        longint y;
        longint due;
    } exp_t;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int w, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s (W=%0d) at %0t: got %0d, expected %0d", nm, w, $time, got, exp);
        end
    endtask

    function automatic longint hyp(input longint x, input longint z, input bit rnd);
        longint s;
        longint r;
        longint t;
        s = x * x + z * z;
        r = 0;
        for (int k = 20; k >= 0; k--) begin
            t = r + (longint'(1) << k);
            if (t * t <= s) r = t;
        end
        if (rnd && (s - r * r > r)) r = r + 1;
        return r;
    endfunction

    for (genvar gi = 0; gi < 4; gi++) begin : g_w
        localparam int W    = (gi == 0) ? 4 : (gi == 1) ? 8 : (gi == 2) ? 12 : 16;
        localparam int NEXH = (W == 4) ? 256 : 0;
        localparam int NRND = (W == 16) ? 120 : 150;

        logic         rst   = 1'b1;
        logic         start = 1'b0;
        logic [W-1:0] a     = '0;
        logic [W-1:0] b     = '0;
        logic         busy;
        logic         ready;
        logic [W:0]   y;

        exp_t   q[$];
        longint cyc       = 0;
        longint next_free = 0;
        longint exp_y     = 0;

        hypot_seq #(
            .WIDTH (W)
        ) dut (
            .clk   (clk),
            .rst   (rst),
            .start (start),
            .a     (a),
            .b     (b),
            .busy  (busy),
            .ready (ready),
            .y     (y)
        );

        always @(posedge rst) begin
            q.delete();
            exp_y = 0;
        end

        // Model: a start is accepted at any edge once the previous job's full
        // 2W+3-edge slot has elapsed; the result is due 2W+1 edges later.
        always @(posedge clk) begin : model
            exp_t e;
            cyc++;
            if (rst) begin
                q.delete();
                exp_y     = 0;
                next_free = cyc + 1;
            end else if (start && cyc >= next_free) begin
                e.y   = hyp(longint'(a), longint'(b), RND);
                e.due = cyc + 2 * W + 1;
                q.push_back(e);
                next_free = cyc + 2 * W + 3;
            end
        end

        always @(negedge clk) begin : cmp
            bit er;
            bit eb;
            if (!rst) begin
                er = (q.size() > 0) && (q[0].due == cyc);
                eb = (q.size() > 0) && (cyc < q[0].due);
                if (er) begin
                    exp_y = q[0].y;
                    void'(q.pop_front());
                end
                check("ready", W, ready, er);
                check("busy", W, busy, eb);
                check("y", W, y, exp_y);
                check("busy_ready_excl", W, busy & ready, 0);
            end
        end

        task automatic tick(input int n);
            repeat (n) @(posedge clk);
            #3;
        endtask

        task automatic do_reset();
            rst   = 1'b1;
            start = 1'b0;
            tick(2);
            check("rst_busy", W, busy, 0);
            check("rst_ready", W, ready, 0);
            check("rst_y", W, y, 0);
            rst = 1'b0;
            tick(1);
        endtask

        // Leaves the bench inside the ready cycle of this job.
        task automatic run(input logic [W-1:0] x, input logic [W-1:0] z);
            start = 1'b1;
            a     = x;
            b     = z;
            tick(1);
            start = 1'b0;
            a     = W'($urandom);
            b     = W'($urandom);
            tick(2 * W + 1);
        endtask

        task automatic op(input logic [W-1:0] x, input logic [W-1:0] z, input longint exp);
            run(x, z);
            check("dir_y", W, y, exp);
            check("dir_ready", W, ready, 1);
            check("dir_busy", W, busy, 0);
            tick(1);
        endtask

        task automatic rnd_phase();
            logic [W-1:0] x;
            logic [W-1:0] z;
            int           k;
            for (int i = 0; i < NEXH; i++) begin
                run(W'(i >> W), W'(i));
                tick(1);
            end
            for (int i = 0; i < NRND; i++) begin
                x = W'($urandom);
                z = W'($urandom);
                k = $urandom_range(0, 7);
                if (k == 0) x = '1;
                if (k == 1) z = '0;
                if (k == 2) begin
                    x = '1;
                    z = '1;
                end
                start = 1'b1;
                a     = x;
                b     = z;
                tick($urandom_range(1, 4));
                start = 1'b0;
                a     = W'($urandom);
                b     = W'($urandom);
                tick($urandom_range(2 * W - 4, 2 * W + 6));
            end
            tick(2 * W + 6);
        endtask

        if (W == 8) begin : g_dir
            localparam int DA[12] = '{3, 5, 8, 10, 15, 8, 55, 1, 2, 0, 0, 255};
            localparam int DB[12] = '{4, 12, 15, 20, 6, 9, 55, 1, 2, 0, 200, 255};
            localparam int DF[12] = '{5, 13, 17, 22, 16, 12, 77, 1, 2, 0, 200, 360};
            localparam int DR[12] = '{5, 13, 17, 22, 16, 12, 78, 1, 3, 0, 200, 361};
            initial begin
                do_reset();
                for (int i = 0; i < 12; i++)
                    op(W'(DA[i]), W'(DB[i]), RND ? DR[i] : DF[i]);
                // start held high while operands churn every cycle
                start = 1'b1;
                repeat (60) begin
                    a = W'($urandom);
                    b = W'($urandom);
                    tick(1);
                end
                start = 1'b0;
                tick(2 * W + 6);
                // abort mid-SQRT
                start = 1'b1;
                a     = 8'd55;
                b     = 8'd55;
                tick(1);
                start = 1'b0;
                tick(W + 3);
                rst = 1'b1;
                #1;
                check("abort_busy", W, busy, 0);
                check("abort_ready", W, ready, 0);
                check("abort_y", W, y, 0);
                tick(1);
                rst = 1'b0;
                tick(2 * W + 6);
                op(8'd3, 8'd4, 5);
                rnd_phase();
                n_done++;
            end
        end else begin : g_rnd
            initial begin
                do_reset();
                rnd_phase();
                n_done++;
            end
        end
    end

    initial begin
        check("model_floor_55", 8, hyp(55, 55, 1'b0), 77);
        check("model_round_55", 8, hyp(55, 55, 1'b1), 78);
        check("model_round_255", 8, hyp(255, 255, 1'b1), 361);
        check("model_round_2", 8, hyp(2, 2, 1'b1), 3);
        fork
            wait (n_done == 4);
            #800000;
        join_any
        check("all_done", 0, n_done, 4);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
